counter_checker: RTL and testbench
==================================

# counter_checker

Synthesizable self-checking monitor for the up/down loadable counter. It observes the counter's control inputs and `count_out` on the counter's own clock and runs a cycle-accurate reference model. It flags the first and every subsequent mismatch and keeps event and coverage tallies. It is the passive, observing end of the counter interface, complementing the stimulus driver, and sits beside the counter in FPGA/emulation builds where no simulator scoreboard exists.

## Interface
Parameters:
- `WIDTH`, 4, counter data width
- `CNT_W`, 16, width of all tally counters
- `STOP_ON_ERR`, 0, 1 = freeze checking after the first mismatch

Ports:
- `clk`  in  1  shared with the observed counter; all logic on the rising edge
- `rst`  in  1  synchronous, active-high checker reset
- `enable`  in  1  checking enabled
- `obs_rst_n`  in  1  counter reset as driven to the counter (active-low)
- `obs_load_n`  in  1  counter load (active-low)
- `obs_ce`  in  1  counter count enable
- `obs_up_down`  in  1  1 = up, 0 = down
- `obs_data_load`  in  WIDTH  counter load value
- `obs_count_out`  in  WIDTH  counter output
- `state`  out  2  checker state, encoded as `chk_state_e`
- `mismatch`  out  1  one-cycle pulse per detected mismatch
- `err_count`  out  CNT_W  saturating mismatch count
- `chk_count`  out  CNT_W  saturating count of compared cycles
- `first_exp`, `first_act`  out  WIDTH  expected and actual values at the first mismatch
- `first_valid`  out  1  the `first_*` outputs hold a captured value
- `load_hits`, `wrap_up_hits`, `wrap_dn_hits`  out  CNT_W  saturating coverage tallies

## Operation
- Reference model, evaluated on every clock edge with priority in this order:
  - `obs_rst_n`=0 → exp=0
  - else `obs_load_n`=0 → exp=`obs_data_load`
  - else `obs_ce`=1 → exp ± 1, modulo 2^WIDTH
  - else hold
- The model is updated in every state, so it tracks the counter even while idle.
- States:
  - IDLE → SYNC when `enable`=1.
  - SYNC → CHECK on the first edge that has `obs_rst_n`=0 or `obs_load_n`=0. From that point exp is known.
  - CHECK: compare and tally each cycle.
  - CHECK → HALT on a mismatch when STOP_ON_ERR=1.
  - Any state → IDLE when `enable`=0. The tally counters are retained.
  - HALT → IDLE only when `enable`=0.
- `model_ok` flag: set on the edge of leaving SYNC, cleared in IDLE. Comparisons happen only when in CHECK with `model_ok`=1.
- Compare rule: at an edge in CHECK, compare `obs_count_out` with the registered exp from the previous edge.
  - `chk_count`+1 for every comparison.
  - On inequality: `mismatch`=1 for one cycle and `err_count`+1.
  - On the first inequality since `rst`: capture `first_exp`/`first_act` and set `first_valid`.
- Coverage, counted only in CHECK:
  - `load_hits`+1 for each cycle with `obs_rst_n`=1 and `obs_load_n`=0.
  - `wrap_up_hits`+1 for each increment from all-ones.
  - `wrap_dn_hits`+1 for each decrement from 0.
- All tallies saturate at 2^CNT_W−1 and do not wrap.
- Simultaneous events:
  - A mismatch and the transition to HALT occur on the same edge; the mismatch is still counted.
  - When `enable` falls during CHECK, the comparison on that edge is suppressed.

## Timing
- Reset values: `state`=IDLE, every output 0, exp=0, `model_ok`=0.
- `rst` asserted in any state restores these values on the next edge and clears the `first_*` capture.
- Latency: a counter error present at edge k+1 produces `mismatch` high in the cycle following edge k+1, one edge after the counter updated at edge k.
- Leaving SYNC on edge s: the first comparison is on edge s+1.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Package `count_chk_pkg`:
  - `typedef enum logic [1:0] {IDLE, SYNC, CHECK, HALT} chk_state_e`
  - function `ref_next(exp, rst_n, load_n, ce, up_down, data_load)`
  - saturating-increment function
- Sub-module `sat_counter` (width CNT_W, `inc` input), instantiated five times for the tallies.

## Test plan
- `enable`=1, drive `obs_rst_n`=0 for 1 cycle, then `ce`=1, up=1, and a correct counter for 20 cycles → state is CHECK, `chk_count`=20, `err_count`=0, `wrap_up_hits`=1 (15→0).
- Load 0, count down 3 cycles with a correct counter → `load_hits`=1, `wrap_dn_hits`=1, exp sequence 0,15,14,13.
- Correct counter, then force `obs_count_out`=5 where exp=7 → one-cycle `mismatch` one edge later, `first_exp`=7, `first_act`=5, `first_valid`=1, `err_count`=1.
- STOP_ON_ERR=1, inject two consecutive errors → state=HALT, `err_count`=1; drop `enable` → IDLE.
- `enable`=1 with no reset or load for 10 cycles → state stays SYNC, `chk_count`=0; then `load_n`=0 with `data_load`=9 → CHECK, and the first comparison expects 9.
- Assert `rst` mid-CHECK with `err_count`=3 → next edge: state=IDLE, all tallies 0, `first_valid`=0.

Source files
------------

// File: rtl/counter_checker_pkg.sv
// Shared types and helpers for the counter_checker monitor: state encoding,
// the reference next-count rule and saturating increment.
package count_chk_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, CHECK, HALT} chk_state_e;

    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
        if (width >= MAX_W)
            return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

    // Helpers work on 32-bit zero-extended values; callers size-cast the result.
    function automatic logic [MAX_W-1:0] ref_next(
        input logic [MAX_W-1:0] exp,
        input logic             rst_n,
        input logic             load_n,
        input logic             ce,
        input logic             up_down,
        input logic [MAX_W-1:0] data_load,
        input int unsigned      width = MAX_W
    );
        logic [MAX_W-1:0] mask;
        mask = width_mask(width);
        if (!rst_n)
            return '0;
        if (!load_n)
            return data_load & mask;
        if (ce)
            return up_down ? ((exp + 32'd1) & mask) : ((exp - 32'd1) & mask);
        return exp & mask;
    endfunction

    function automatic logic [MAX_W-1:0] sat_inc(
        input logic [MAX_W-1:0] value,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        mask = width_mask(width);
        if ((value & mask) == mask)
            return mask;
        return (value + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating event tally: counts inc pulses, sticks at all-ones.
module sat_counter
    import count_chk_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc)
            count <= CNT_W'(sat_inc(32'(count), CNT_W));
    end

endmodule

// File: rtl/counter_checker.sv
// Passive checker for the up/down loadable counter: tracks a reference model,
// compares count_out each cycle once synchronised, and keeps tallies.
module counter_checker
    import count_chk_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             obs_rst_n,
    input  logic             obs_load_n,
    input  logic             obs_ce,
    input  logic             obs_up_down,
    input  logic [WIDTH-1:0] obs_data_load,
    input  logic [WIDTH-1:0] obs_count_out,
    output logic [1:0]       state,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic             first_valid,
    output logic [CNT_W-1:0] load_hits,
    output logic [CNT_W-1:0] wrap_up_hits,
    output logic [CNT_W-1:0] wrap_dn_hits
);

    chk_state_e       state_q;
    logic [WIDTH-1:0] exp_q;
    logic             model_ok;

    logic do_cmp;
    logic is_diff;
    logic sync_hit;
    logic plain_count;
    logic inc_load;
    logic inc_wrap_up;
    logic inc_wrap_dn;

    // A falling enable during CHECK suppresses that edge's comparison.
    assign do_cmp      = (state_q == CHECK) && model_ok && enable;
    assign is_diff     = do_cmp && (obs_count_out != exp_q);
    assign sync_hit    = !obs_rst_n || !obs_load_n;
    assign plain_count = obs_rst_n && obs_load_n && obs_ce;
    assign inc_load    = do_cmp && obs_rst_n && !obs_load_n;
    assign inc_wrap_up = do_cmp && plain_count && obs_up_down && (exp_q == '1);
    assign inc_wrap_dn = do_cmp && plain_count && !obs_up_down && (exp_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            model_ok    <= 1'b0;
            mismatch    <= 1'b0;
            first_exp   <= '0;
            first_act   <= '0;
            first_valid <= 1'b0;
        end else begin
            // The model runs in every state so it is current when checking resumes.
            exp_q    <= WIDTH'(ref_next(32'(exp_q), obs_rst_n, obs_load_n, obs_ce,
                                        obs_up_down, 32'(obs_data_load), WIDTH));
            mismatch <= is_diff;

            if (is_diff && !first_valid) begin
                first_exp   <= exp_q;
                first_act   <= obs_count_out;
                first_valid <= 1'b1;
            end

            if (state_q == IDLE)
                model_ok <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (enable)
                        state_q <= SYNC;
                end
                SYNC: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (sync_hit) begin
                        state_q  <= CHECK;
                        model_ok <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!enable)
                        state_q <= IDLE;
                    else if (is_diff && STOP_ON_ERR)
                        state_q <= HALT;
                end
                HALT: begin
                    if (!enable)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
        .clk(clk), .rst(rst), .inc(do_cmp), .count(chk_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(clk), .rst(rst), .inc(is_diff), .count(err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clk(clk), .rst(rst), .inc(inc_load), .count(load_hits)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_up_cnt (
        .clk(clk), .rst(rst), .inc(inc_wrap_up), .count(wrap_up_hits)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_dn_cnt (
        .clk(clk), .rst(rst), .inc(inc_wrap_dn), .count(wrap_dn_hits)
    );

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: a behavioural counter drives the observed
// bus, a reference model predicts every output, a monitor compares each cycle.
module tb_counter_checker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_A = 16;
    localparam int unsigned CNT_B = 3;
    localparam int MODV     = 1 << WIDTH;
    localparam int ST_IDLE  = 0;
    localparam int ST_SYNC  = 1;
    localparam int ST_CHECK = 2;
    localparam int ST_HALT  = 3;

    logic clk = 1'b0;
    logic rst, enable, obs_rst_n, obs_load_n, obs_ce, obs_up_down;
    logic [WIDTH-1:0] obs_data_load, obs_count_out;

    logic [1:0]       a_state, b_state;
    logic             a_mm, b_mm, a_fv, b_fv;
    logic [CNT_A-1:0] a_err, a_chk, a_ld, a_wu, a_wd;
    logic [CNT_B-1:0] b_err, b_chk, b_ld, b_wu, b_wd;
    logic [WIDTH-1:0] a_fexp, a_fact, b_fexp, b_fact;

    always #5 clk = ~clk;

    counter_checker #(.WIDTH(WIDTH), .CNT_W(CNT_A), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .obs_rst_n(obs_rst_n),
        .obs_load_n(obs_load_n), .obs_ce(obs_ce), .obs_up_down(obs_up_down),
        .obs_data_load(obs_data_load), .obs_count_out(obs_count_out),
        .state(a_state), .mismatch(a_mm), .err_count(a_err), .chk_count(a_chk),
        .first_exp(a_fexp), .first_act(a_fact), .first_valid(a_fv),
        .load_hits(a_ld), .wrap_up_hits(a_wu), .wrap_dn_hits(a_wd)
    );

    counter_checker #(.WIDTH(WIDTH), .CNT_W(CNT_B), .STOP_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .obs_rst_n(obs_rst_n),
        .obs_load_n(obs_load_n), .obs_ce(obs_ce), .obs_up_down(obs_up_down),
        .obs_data_load(obs_data_load), .obs_count_out(obs_count_out),
        .state(b_state), .mismatch(b_mm), .err_count(b_err), .chk_count(b_chk),
        .first_exp(b_fexp), .first_act(b_fact), .first_valid(b_fv),
        .load_hits(b_ld), .wrap_up_hits(b_wu), .wrap_dn_hits(b_wd)
    );

    typedef struct {
        int st; bit ok; int exp; bit mm;
        int err; int chk; int ld; int wu; int wd;
        int fexp; int fact; bit fv;
    } model_t;

    model_t ma = '{default: 0};
    model_t mb = '{default: 0};
    model_t qa[$];
    model_t qb[$];
    int vectors = 0;
    int miscompares = 0;
    int cnt = 0;

    function automatic int count_next(int v, bit rn, bit ln, bit ce, bit up, int dl);
        if (!rn) return 0;
        if (!ln) return dl % MODV;
        if (ce) return (v + (up ? 1 : MODV - 1)) % MODV;
        return v;
    endfunction

    function automatic int bump(int v, int top);
        return (v >= top) ? top : v + 1;
    endfunction

    function automatic model_t step(model_t m, bit stop, int top, bit r, bit en,
                                    bit rn, bit ln, bit ce, bit up, int dl, int act);
        model_t n;
        bit cmp, diff;
        n = m;
        if (r) return '{default: 0};
        cmp  = (m.st == ST_CHECK) && m.ok && en;
        diff = cmp && (act != m.exp);
        n.mm = diff;
        if (cmp) begin
            n.chk = bump(m.chk, top);
            if (rn && !ln) n.ld = bump(m.ld, top);
            if (rn && ln && ce && up && m.exp == MODV - 1) n.wu = bump(m.wu, top);
            if (rn && ln && ce && !up && m.exp == 0) n.wd = bump(m.wd, top);
        end
        if (diff) begin
            n.err = bump(m.err, top);
            if (!m.fv) begin
                n.fv = 1'b1; n.fexp = m.exp; n.fact = act;
            end
        end
        n.exp = count_next(m.exp, rn, ln, ce, up, dl);
        if (m.st == ST_IDLE) n.ok = 1'b0;
        if (!en) n.st = ST_IDLE;
        else if (m.st == ST_IDLE) n.st = ST_SYNC;
        else if (m.st == ST_SYNC && (!rn || !ln)) begin
            n.st = ST_CHECK; n.ok = 1'b1;
        end else if (m.st == ST_CHECK && diff && stop) n.st = ST_HALT;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit en, input bit rn, input bit ln, input bit ce,
                         input bit up, input int dl, input bit corrupt, input int bad);
        int act;
        @(negedge clk);
        act = corrupt ? bad : cnt;
        rst = r; enable = en; obs_rst_n = rn; obs_load_n = ln; obs_ce = ce;
        obs_up_down = up; obs_data_load = WIDTH'(dl); obs_count_out = WIDTH'(act);
        @(posedge clk);
        ma = step(ma, 1'b0, (1 << CNT_A) - 1, r, en, rn, ln, ce, up, dl, act);
        mb = step(mb, 1'b1, (1 << CNT_B) - 1, r, en, rn, ln, ce, up, dl, act);
        qa.push_back(ma);
        qb.push_back(mb);
        cnt = count_next(cnt, rn, ln, ce, up, dl);
    endtask

    task automatic tick(input bit en, input bit rn, input bit ln, input bit ce,
                        input bit up, input int dl);
        apply(1'b0, en, rn, ln, ce, up, dl, 1'b0, 0);
    endtask

    initial begin : monitor
        model_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a.state", a_state, e.st);    check("a.mismatch", a_mm, e.mm);
                check("a.err_count", a_err, e.err); check("a.chk_count", a_chk, e.chk);
                check("a.load_hits", a_ld, e.ld);   check("a.wrap_up", a_wu, e.wu);
                check("a.wrap_dn", a_wd, e.wd);     check("a.first_valid", a_fv, e.fv);
                check("a.first_exp", a_fexp, e.fexp); check("a.first_act", a_fact, e.fact);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b.state", b_state, e.st);    check("b.mismatch", b_mm, e.mm);
                check("b.err_count", b_err, e.err); check("b.chk_count", b_chk, e.chk);
                check("b.load_hits", b_ld, e.ld);   check("b.wrap_up", b_wu, e.wu);
                check("b.wrap_dn", b_wd, e.wd);     check("b.first_valid", b_fv, e.fv);
                check("b.first_exp", b_fexp, e.fexp); check("b.first_act", b_fact, e.fact);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; enable = 1'b0; obs_rst_n = 1'b0; obs_load_n = 1'b1; obs_ce = 1'b0;
        obs_up_down = 1'b1; obs_data_load = '0; obs_count_out = '0;
        repeat (2) apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);

        // Sync on counter reset, then 20 correct up-counts through a wrap.
        tick(1, 1, 1, 0, 1, 0);
        tick(1, 0, 1, 0, 1, 0);
        repeat (20) tick(1, 1, 1, 1, 1, 0);
        #1;
        check("t1.state", a_state, ST_CHECK); check("t1.chk_count", a_chk, 20);
        check("t1.err_count", a_err, 0);     check("t1.wrap_up", a_wu, 1);

        // Load 0 then count down through the 0 -> 15 wrap.
        tick(1, 1, 0, 0, 1, 0);
        repeat (3) tick(1, 1, 1, 1, 0, 0);
        #1;
        check("t2.load_hits", a_ld, 1); check("t2.wrap_dn", a_wd, 1);
        check("t2.chk_count", a_chk, 24);

        // Counter at 7, observed value forced to 5.
        tick(1, 1, 0, 0, 1, 6);
        tick(1, 1, 1, 1, 1, 0);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 5);
        #1;
        check("t3.mismatch", a_mm, 1);   check("t3.first_exp", a_fexp, 7);
        check("t3.first_act", a_fact, 5); check("t3.first_valid", a_fv, 1);
        check("t3.err_count", a_err, 1); check("t3.halt_state", b_state, ST_HALT);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 5);
        #1;
        check("t4.halt_err", b_err, 1);      check("t4.halt_state", b_state, ST_HALT);
        check("t4.err_count", a_err, 2);     check("t4.first_exp", a_fexp, 7);
        tick(1, 1, 1, 0, 1, 0);
        #1;
        check("t4.mismatch_clear", a_mm, 0);
        tick(0, 1, 1, 0, 1, 0);
        #1;
        check("t4.idle_a", a_state, ST_IDLE); check("t4.idle_b", b_state, ST_IDLE);

        // No reset or load while enabled: stays in SYNC, then syncs on load 9.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
        repeat (11) tick(1, 1, 1, 1, 1'($urandom_range(0, 1)), 0);
        #1;
        check("t5.state", a_state, ST_SYNC); check("t5.chk_count", a_chk, 0);
        tick(1, 1, 0, 0, 1, 9);
        tick(1, 1, 1, 0, 1, 0);
        #1;
        check("t5.chk_after", a_chk, 1); check("t5.err_after", a_err, 0);
        check("t5.check_state", a_state, ST_CHECK);

        // Three errors, then checker reset mid-CHECK.
        repeat (3) apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, (cnt + 3) % MODV);
        #1;
        check("t6.err_count", a_err, 3);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
        #1;
        check("t6.state", a_state, ST_IDLE); check("t6.err_zero", a_err, 0);
        check("t6.chk_zero", a_chk, 0);      check("t6.load_zero", a_ld, 0);
        check("t6.first_valid", a_fv, 0);    check("t6.halt_reset", b_state, ST_IDLE);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            bit r, en, rn, ln, corrupt;
            r       = ($urandom_range(0, 99) < 1);
            en      = ($urandom_range(0, 99) < 95);
            rn      = ($urandom_range(0, 99) < 95);
            ln      = ($urandom_range(0, 99) < 88);
            corrupt = ($urandom_range(0, 99) < 5);
            apply(r, en, rn, ln, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, MODV - 1)), corrupt,
                  (cnt + int'($urandom_range(1, MODV - 1))) % MODV);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
